s386_bist_ctrl: RTL and testbench
=================================

Name: s386_bist_ctrl

Overview:
- Built-in self-test controller for the s386 benchmark core.
- Sequences a test run in three steps:
  - flush: drives a fixed input vector into the core to settle its state;
  - run: applies NUM_PATTERNS pseudo-random 7-bit vectors from an LFSR to v0..v6;
  - compact: folds the 7 core outputs into a MISR signature each cycle.
- After the run, compares the signature with a golden value and reports pass/fail.
- Sits between the test bench or top-level test logic and the core instance, sharing the core's clock.

Parameters:
- NUM_PATTERNS, 127: vectors applied in RUN; legal range 1..255.
- FLUSH_CYCLES, 8: cycles of all-zero input before RUN; legal range 1..255.
- LFSR_SEED, 7'h01: LFSR value at RUN entry; must be nonzero.
- GOLDEN_SIG, 7'h00: expected final MISR value.

Ports:
- CK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-high.
- start  input  1  start request, single-cycle pulse.
- busy  output  1  high in FLUSH, RUN and CHECK.
- done  output  1  high in DONE.
- pass  output  1  compare result, valid while done=1.
- cut_in  output  7  drives core inputs v0..v6 (bit0 = v0).
- cut_out  input  7  core outputs v13_D_6..v13_D_12 (bit0 = v13_D_6).
- signature  output  7  current MISR register.
- pattern_count  output  8  patterns applied in the current run.

Behaviour:
- One clock, CK. Reset is asynchronous and active-high on RST; all flops clear immediately on assertion.
- Reset values:
  - state = IDLE;
  - cut_in, signature and pattern_count = 0;
  - busy, done and pass = 0;
  - LFSR = LFSR_SEED;
  - flush counter = 0.
- States: IDLE, FLUSH, RUN, CHECK, DONE.
  - IDLE: start=1 → FLUSH; clear flush counter, MISR and pattern_count.
  - FLUSH:
    - cut_in = 0; MISR not updated.
    - Counter increments each cycle.
    - After FLUSH_CYCLES cycles → RUN, with LFSR loaded to LFSR_SEED.
  - RUN:
    - cut_in = LFSR value, driven combinationally from the LFSR register.
    - Core response is combinational in the same cycle. Each edge:
      - MISR <= {sig[5:0], sig[6]^sig[5]} ^ cut_out;
      - LFSR <= {q[5:0], q[6]^q[5]} (x^7+x^6+1, period 127);
      - pattern_count <= pattern_count + 1.
    - On the edge where pattern_count becomes NUM_PATTERNS → CHECK.
    - Exactly NUM_PATTERNS cycles spent in RUN.
  - CHECK: one cycle; cut_in = 0; pass <= (signature == GOLDEN_SIG) → DONE.
  - DONE:
    - done = 1; pass, signature and pattern_count held.
    - start=1 → FLUSH (restart; clears everything as in IDLE).
- start while busy=1 is ignored; no queueing.
- Latency from start edge to done=1: FLUSH_CYCLES + NUM_PATTERNS + 1 cycles.
- RST mid-run: immediate return to IDLE and reset values. The core's own state is not reset, so a new run always flushes first.
- pattern_count saturates at NUM_PATTERNS; it never wraps.
- The LFSR never reaches 0 from a nonzero seed.
- A LFSR_SEED of 0 is a configuration error; flag it with a simulation-time error in an initial block.

Optional Feature:
- Macro: BIST_ABORT_EN.
- Defined:
  - adds input port abort (1 bit).
  - abort=1 in FLUSH, RUN or CHECK → DONE next edge with pass=0; signature and pattern_count frozen at their current values.
  - abort in IDLE or DONE is ignored.
  - abort has priority over the normal RUN → CHECK transition in the same cycle.
- Undefined: no abort port; internal abort tied 0.

Test Plan:
- Reset: assert RST mid-RUN at any cycle → same cycle all outputs 0 and state IDLE; a later start performs a full flush of FLUSH_CYCLES cycles.
- LFSR sequence: NUM_PATTERNS=8, LFSR_SEED=1, FLUSH_CYCLES=2 → cut_in 00,00 then 01,02,04,08,10,20,41,03; done rises 11 cycles after start.
- MISR: stub core with cut_out = 7'h01 constant, NUM_PATTERNS=3 → signature 01,03,07; GOLDEN_SIG=7'h07 gives pass=1, GOLDEN_SIG=7'h06 gives pass=0.
- Restart and ignore: start pulsed during RUN → no effect, count continues. start in DONE → done drops next cycle and busy=1; signature cleared to 0.
- Golden run: real s386 core, defaults, 127 patterns → pattern_count=127 and signature equals the bench reference model; pass=1 when GOLDEN_SIG is set to that value.
- BIST_ABORT_EN: abort at the 5th RUN cycle → DONE next edge, pass=0, pattern_count=4. Without the macro the port is absent and the build still compiles.

Source files
------------

// File: rtl/s386_bist_ctrl.sv
// s386_bist_ctrl -- built-in self-test controller for the s386 benchmark core.
//
// Runs one self-test per start pulse:
//   FLUSH : FLUSH_CYCLES cycles of all-zero input to settle the core state
//   RUN   : NUM_PATTERNS pseudo-random vectors from a 7-bit LFSR
//           (x^7+x^6+1). The core response is folded into a 7-bit MISR
//           on every RUN edge.
//   CHECK : compare the MISR with GOLDEN_SIG
//   DONE  : result held until the next start
//
// Optional feature macro: BIST_ABORT_EN
//   When defined, an extra input port 'abort' is added. Asserting it in
//   FLUSH/RUN/CHECK ends the run in DONE with pass=0. Signature and
//   pattern_count keep their current values. When the macro is undefined,
//   the abort path is tied off internally.
//
// Ports:
//   CK            in   clock, rising edge
//   RST           in   asynchronous active-high reset
//   start         in   start request (single-cycle pulse); ignored while busy
//   abort         in   (BIST_ABORT_EN only) abort the current run
//   busy          out  high in FLUSH, RUN, CHECK
//   done          out  high in DONE
//   pass          out  signature compare result, valid while done=1
//   cut_in[6:0]   out  core inputs v0..v6 (bit0 = v0)
//   cut_out[6:0]  in   core outputs v13_D_6..v13_D_12 (bit0 = v13_D_6)
//   signature     out  current MISR value
//   pattern_count out  patterns applied in the current run

module s386_bist_ctrl #(
  parameter int         NUM_PATTERNS = 127,
  parameter int         FLUSH_CYCLES = 8,
  parameter logic [6:0] LFSR_SEED    = 7'h01,
  parameter logic [6:0] GOLDEN_SIG   = 7'h00
) (
  input  logic       CK,
  input  logic       RST,
  input  logic       start,
`ifdef BIST_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] cut_in,
  input  logic [6:0] cut_out,
  output logic [6:0] signature,
  output logic [7:0] pattern_count
);

  localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_CYCLES - 1);
  localparam logic [7:0] NUM_PAT    = 8'(NUM_PATTERNS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] flush_cnt_q, flush_cnt_d;
  logic [6:0] lfsr_q, lfsr_d;
  logic [6:0] misr_q, misr_d;
  logic [7:0] pcnt_q, pcnt_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic       abort_w;

`ifdef BIST_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    lfsr_d      = lfsr_q;
    misr_d      = misr_q;
    pcnt_d      = pcnt_q;
    pass_d      = pass_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // A start from IDLE or a restart from DONE both begin a fresh run;
        // the core is never reset, so every run flushes first.
        if (start) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
          misr_d      = '0;
          pcnt_d      = '0;
          pass_d      = 1'b0;
        end
      end

      ST_FLUSH: begin
        if (abort_w) begin
          state_d = ST_DONE;
          pass_d  = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt_q + 8'd1;
          if (flush_cnt_q == FLUSH_LAST) begin
            state_d = ST_RUN;
            lfsr_d  = LFSR_SEED;
          end
        end
      end

      ST_RUN: begin
        // Abort wins over the RUN->CHECK step and freezes MISR/count.
        if (abort_w) begin
          state_d = ST_DONE;
          pass_d  = 1'b0;
        end else begin
          misr_d = {misr_q[5:0], misr_q[6] ^ misr_q[5]} ^ cut_out;
          lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
          pcnt_d = pcnt_q + 8'd1;
          // Leaving RUN on this edge is what keeps the count saturated.
          if (pcnt_q + 8'd1 == NUM_PAT) begin
            state_d = ST_CHECK;
          end
        end
      end

      ST_CHECK: begin
        state_d = ST_DONE;
        pass_d  = abort_w ? 1'b0 : (misr_q == GOLDEN_SIG);
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up
    // with the state register.
    busy_d = (state_d == ST_FLUSH) || (state_d == ST_RUN) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= '0;
      lfsr_q      <= LFSR_SEED;
      misr_q      <= '0;
      pcnt_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      lfsr_q      <= lfsr_d;
      misr_q      <= misr_d;
      pcnt_q      <= pcnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  // The core responds combinationally, so the vector must be on cut_in in
  // the same cycle that the MISR samples cut_out.
  assign cut_in        = (state_q == ST_RUN) ? lfsr_q : 7'h00;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign signature     = misr_q;
  assign pattern_count = pcnt_q;

`ifndef SYNTHESIS
  initial begin
    if (LFSR_SEED == 7'h00) begin
      $error("s386_bist_ctrl: LFSR_SEED must be nonzero (an all-zero LFSR never advances)");
    end
  end
`endif

endmodule

// File: tb/tb_s386_bist_ctrl.sv
// Directed bench for s386_bist_ctrl. Four instances with different
// configurations share the clock and reset:
//   u_a : NUM_PATTERNS=8, FLUSH_CYCLES=2, seed 1, cut_out looped from cut_in
//   u_b : NUM_PATTERNS=3, FLUSH_CYCLES=2, cut_out=7'h01, GOLDEN_SIG=7'h07
//   u_c : same as u_b with GOLDEN_SIG=7'h06
//   u_d : defaults, stub core, GOLDEN_SIG from the bench reference model

module tb_s386_bist_ctrl;

  logic CK;
  logic RST;
  int   n_assert;
  int   n_fail;

  function automatic logic [6:0] core_stub(input logic [6:0] v);
    return {v[3:0], v[6:4]} ^ 7'h2A;
  endfunction

  function automatic logic [6:0] ref_sig();
    logic [6:0] q;
    logic [6:0] s;
    q = 7'h01;
    s = 7'h00;
    for (int i = 0; i < 127; i++) begin
      s = {s[5:0], s[6] ^ s[5]} ^ core_stub(q);
      q = {q[5:0], q[6] ^ q[5]};
    end
    return s;
  endfunction

  localparam logic [6:0] REF_SIG = ref_sig();

  logic       start_a, start_b, start_c, start_d;
  logic       abort_a, abort_o;
  logic       busy_a, done_a, pass_a;
  logic       busy_b, done_b, pass_b;
  logic       busy_c, done_c, pass_c;
  logic       busy_d, done_d, pass_d;
  logic [6:0] cut_in_a, cut_in_b, cut_in_c, cut_in_d;
  logic [6:0] cut_out_a, cut_out_d;
  logic [6:0] sig_a, sig_b, sig_c, sig_d;
  logic [7:0] pc_a, pc_b, pc_c, pc_d;

  assign cut_out_a = cut_in_a;
  assign cut_out_d = core_stub(cut_in_d);
  assign abort_o   = 1'b0;

  s386_bist_ctrl #(.NUM_PATTERNS(8), .FLUSH_CYCLES(2), .LFSR_SEED(7'h01), .GOLDEN_SIG(7'h00)) u_a (
    .CK(CK), .RST(RST), .start(start_a),
`ifdef BIST_ABORT_EN
    .abort(abort_a),
`endif
    .busy(busy_a), .done(done_a), .pass(pass_a), .cut_in(cut_in_a), .cut_out(cut_out_a),
    .signature(sig_a), .pattern_count(pc_a));

  s386_bist_ctrl #(.NUM_PATTERNS(3), .FLUSH_CYCLES(2), .LFSR_SEED(7'h01), .GOLDEN_SIG(7'h07)) u_b (
    .CK(CK), .RST(RST), .start(start_b),
`ifdef BIST_ABORT_EN
    .abort(abort_o),
`endif
    .busy(busy_b), .done(done_b), .pass(pass_b), .cut_in(cut_in_b), .cut_out(7'h01),
    .signature(sig_b), .pattern_count(pc_b));

  s386_bist_ctrl #(.NUM_PATTERNS(3), .FLUSH_CYCLES(2), .LFSR_SEED(7'h01), .GOLDEN_SIG(7'h06)) u_c (
    .CK(CK), .RST(RST), .start(start_c),
`ifdef BIST_ABORT_EN
    .abort(abort_o),
`endif
    .busy(busy_c), .done(done_c), .pass(pass_c), .cut_in(cut_in_c), .cut_out(7'h01),
    .signature(sig_c), .pattern_count(pc_c));

  s386_bist_ctrl #(.GOLDEN_SIG(REF_SIG)) u_d (
    .CK(CK), .RST(RST), .start(start_d),
`ifdef BIST_ABORT_EN
    .abort(abort_o),
`endif
    .busy(busy_d), .done(done_d), .pass(pass_d), .cut_in(cut_in_d), .cut_out(cut_out_d),
    .signature(sig_d), .pattern_count(pc_d));

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [6:0] lfsr_exp [8];
  logic [6:0] misr_exp [8];
  int         cyc;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    lfsr_exp = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};
    // signature seen in RUN cycle i with cut_out looped back from cut_in
    misr_exp = '{7'h00, 7'h01, 7'h00, 7'h04, 7'h00, 7'h10, 7'h00, 7'h41};
    start_a = 0; start_b = 0; start_c = 0; start_d = 0; abort_a = 0;
    RST = 1'b1;
    #7;
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_cut_in", cut_in_a, 0);
    chk("rst_sig", sig_a, 0);
    chk("rst_pc", pc_a, 0);
    #5 RST = 1'b0;
    tick();

    // LFSR sequence, start ignored while busy, done latency
    start_a = 1; tick(); start_a = 0;
    chk("flush0_busy", busy_a, 1);
    chk("flush0_cut_in", cut_in_a, 0);
    tick();
    chk("flush1_cut_in", cut_in_a, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("run_cut_in[%0d]", i), cut_in_a, lfsr_exp[i]);
      chk($sformatf("run_pc[%0d]", i), pc_a, i);
      chk($sformatf("run_sig[%0d]", i), sig_a, misr_exp[i]);
      start_a = (i == 2);
      tick();
      start_a = 0;
    end
    chk("check_busy", busy_a, 1);
    chk("check_done", done_a, 0);
    chk("check_cut_in", cut_in_a, 0);
    chk("check_pc", pc_a, 8);
    tick();
    chk("done11_done", done_a, 1);
    chk("done11_busy", busy_a, 0);
    chk("done11_pass", pass_a, 1);
    chk("done11_pc", pc_a, 8);
    tick();
    chk("done_hold_pc", pc_a, 8);

    // MISR with constant cut_out = 01, pass and fail golden values
    start_b = 1; start_c = 1; tick(); start_b = 0; start_c = 0;
    tick(); tick();
    chk("misr_sig0", sig_b, 7'h00);
    tick();
    chk("misr_sig1", sig_b, 7'h01);
    tick();
    chk("misr_sig2", sig_b, 7'h03);
    tick();
    chk("misr_sig3", sig_b, 7'h07);
    chk("misr_pc3", pc_b, 3);
    chk("misr_check_busy", busy_b, 1);
    tick();
    chk("misr_b_done", done_b, 1);
    chk("misr_b_pass", pass_b, 1);
    chk("misr_c_done", done_c, 1);
    chk("misr_c_pass", pass_c, 0);
    chk("misr_c_sig", sig_c, 7'h07);

    // restart from DONE
    start_b = 1; tick(); start_b = 0;
    chk("restart_done", done_b, 0);
    chk("restart_busy", busy_b, 1);
    chk("restart_sig", sig_b, 0);
    chk("restart_pc", pc_b, 0);

    // golden run against the stub core and reference model
    start_d = 1; tick(); start_d = 0;
    cyc = 0;
    while (!done_d && cyc < 400) begin
      tick();
      cyc++;
    end
    chk("golden_latency", cyc, 136);
    chk("golden_pc", pc_d, 127);
    chk("golden_sig", sig_d, REF_SIG);
    chk("golden_pass", pass_d, 1);

`ifdef BIST_ABORT_EN
    // abort in the fifth RUN cycle
    start_a = 1; tick(); start_a = 0;
    tick(); tick();
    tick(); tick(); tick(); tick();
    chk("abort_pre_pc", pc_a, 4);
    abort_a = 1; tick(); abort_a = 0;
    chk("abort_done", done_a, 1);
    chk("abort_busy", busy_a, 0);
    chk("abort_pass", pass_a, 0);
    chk("abort_pc", pc_a, 4);
    tick();
    chk("abort_hold_pc", pc_a, 4);
`endif

    // asynchronous reset in the middle of RUN, then a full flush
    start_a = 1; tick(); start_a = 0;
    tick(); tick(); tick(); tick();
    chk("mid_pre_pc", pc_a, 2);
    chk("mid_pre_cut_in", cut_in_a, 7'h04);
    #2 RST = 1'b1;
    #1;
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_cut_in", cut_in_a, 0);
    chk("mid_rst_pc", pc_a, 0);
    chk("mid_rst_done", done_a, 0);
    #1 RST = 1'b0;
    tick();
    start_a = 1; tick(); start_a = 0;
    chk("reflush0_busy", busy_a, 1);
    chk("reflush0_cut_in", cut_in_a, 0);
    tick();
    chk("reflush1_cut_in", cut_in_a, 0);
    tick();
    chk("rerun_cut_in", cut_in_a, 7'h01);
    chk("rerun_pc", pc_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
